packet_cutter_cfg_sequencer: RTL and testbench
==============================================

Name: packet_cutter_cfg_sequencer

Overview:
- AXI4-Lite write master that programs the packet cutter's control registers in a fixed, safe order from one start pulse.
- Sits between the monitor's host/config logic and the cutter's S_AXI slave port.
- Replaces ad-hoc register pokes: disables cutting, loads word/offset/bytes, re-enables, then reports done or error.

Parameters:
- C_BASE_ADDR, 32'h77800000, cutter register base address.
- C_S_AXI_ADDR_WIDTH, 32, AXI-Lite address width.
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; fixed at 32.
- C_TIMEOUT, 256, max cycles per write transaction before abort.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  single-cycle pulse; begins a sequence when idle
- cfg_word  in  32  value for WORD register (+0x4)
- cfg_offset  in  32  value for OFFSET/mask register (+0x8)
- cfg_bytes  in  32  value for BYTES register (+0xC)
- cfg_enable  in  1  final value of CUT enable (+0x0, bit 0)
- busy  out  1  high from accepted start to done
- done  out  1  one-cycle pulse at end of sequence
- error  out  1  sticky; set on BRESP!=OKAY or timeout, cleared by next accepted start
- err_index  out  3  step index at which error occurred
- m_axi_awaddr  out  32  write address
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32
- m_axi_wstrb  out  4  always 4'hF
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

Behaviour:
- Reset: busy, done, error, awvalid, wvalid, bready = 0; err_index = 0; awaddr = wdata = 0; state IDLE; step = 0; timeout counter = 0.
- cfg_start in IDLE: latch all cfg_* inputs into shadow registers, clear error/err_index, step=0, busy=1, go ISSUE next cycle. cfg_start while busy is ignored. Inputs are not sampled after latching.
- Step table (step 0..4): 0: +0x0 <= 0 (cut disable); 1: +0x4 <= word; 2: +0x8 <= offset; 3: +0xC <= bytes; 4: +0x0 <= {31'b0, enable}.
- ISSUE: awaddr = C_BASE_ADDR + step offset; wdata = step value; assert awvalid and wvalid in the same cycle. Each valid drops the cycle after its own ready is sampled high; the address and data channels complete independently, in either order or together. Go WAIT_RESP once both have handshaked.
- WAIT_RESP: bready = 1. On bvalid: if bresp == 2'b00, step 4 goes DONE, else step+1 and back to ISSUE; if bresp != 0, error=1, err_index=step, go DONE.
- Timeout: counter clears on entering ISSUE and increments each cycle in ISSUE/WAIT_RESP. At C_TIMEOUT-1, drop all valids and bready, set error, err_index=step, go DONE. A ready or bvalid arriving in the timeout cycle is ignored.
- DONE: done=1 for one cycle, busy=0, return IDLE. Minimum sequence latency with zero-wait slave: 5 x 3 cycles + 1 cycles from start to done.
- An error on step 0 leaves the cutter's enable unknown. An error on steps 1-3 leaves cutting disabled. The sequence never skips to step 4 after an error.
- Reset mid-sequence: all valids/bready low at the next edge. No completion of the in-flight write is attempted.
- Valid signals never depend combinationally on ready (AXI rule).

Decomposition:
- Shared package/header: register offsets (CUT_EN 0x0, WORD 0x4, OFFSET 0x8, BYTES 0xC), BRESP_OKAY, state encoding (IDLE, ISSUE, WAIT_RESP, DONE), NUM_STEPS=5.
- One natural sub-module, axil_single_write: issues one AW/W/B transaction with timeout and returns ok/err. The sequencer FSM only steps the table.

Test Plan:
- Zero-wait slave, start with word=1, offset=ffe00000, bytes=4b, enable=1 -> writes observed in order (0x77800000,0), (..04,1), (..08,ffe00000), (..0C,4b), (..00,1). Done at cycle 16 after start; error=0.
- Slave holds wready 3 cycles after awready, then bvalid 2 cycles later -> awvalid drops after its handshake, wvalid stays until wready, data unchanged, sequence completes.
- bresp=2'b10 on step 2 -> error=1, err_index=2, done pulse, no step 3/4 writes issued.
- Slave never asserts bvalid -> after C_TIMEOUT=256 cycles in step 0, valids low, error=1, err_index=0, done pulse. Next start clears error.
- cfg_start pulsed again during busy, with changed cfg_bytes -> ignored; original bytes written; exactly 5 writes.
- Reset asserted mid step 3 while awvalid high -> awvalid/wvalid/busy 0 next cycle; a new start afterwards runs a full 5-write sequence.

Source files
------------

// File: rtl/packet_cutter_cfg_sequencer_pkg.sv
// packet_cutter_cfg_sequencer_pkg: register map, response codes and FSM encoding for the cutter config sequencer
package packet_cutter_cfg_sequencer_pkg;
  localparam logic [31:0] OFF_CUT_EN = 32'h0;
  localparam logic [31:0] OFF_WORD = 32'h4;
  localparam logic [31:0] OFF_OFFSET = 32'h8;
  localparam logic [31:0] OFF_BYTES = 32'hC;
  localparam logic [1:0] BRESP_OKAY = 2'b00;
  localparam int NUM_STEPS = 5;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DONE} state_t;
  function automatic logic [31:0] step_offset(input logic [2:0] step);
    return step == 3'd1 ? OFF_WORD : step == 3'd2 ? OFF_OFFSET : step == 3'd3 ? OFF_BYTES : OFF_CUT_EN;
  endfunction
endpackage

// File: rtl/packet_cutter_cfg_sequencer_if.sv
// packet_cutter_cfg_sequencer_if: AXI4-Lite write channels toward the cutter's S_AXI port
interface packet_cutter_cfg_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic awvalid;
  logic awready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input awready, wready, bresp, bvalid
  );
  modport slave (
    input awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/packet_cutter_cfg_sequencer_axil_single_write.sv
// axil_single_write: one AXI4-Lite AW/W/B write with a per-transaction timeout
module axil_single_write
  import packet_cutter_cfg_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 256
) (
  input logic clk,
  input logic reset,
  input logic go,
  input logic [ADDR_W-1:0] addr,
  input logic [DATA_W-1:0] data,
  packet_cutter_cfg_sequencer_if.master m,
  output logic ok,
  output logic err
);
  localparam int CW = $clog2(TIMEOUT);
  logic active;
  logic [CW-1:0] cnt;
  logic timeout;
  logic b_hs;
  // a late ready or bvalid in the abort cycle must not count as completion
  assign timeout = active && cnt == CW'(TIMEOUT - 1);
  assign b_hs = m.bready && m.bvalid && !timeout;
  assign ok = b_hs && m.bresp == BRESP_OKAY;
  assign err = timeout || (b_hs && m.bresp != BRESP_OKAY);
  assign m.wstrb = '1;
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      cnt <= '0;
      m.awvalid <= 1'b0;
      m.wvalid <= 1'b0;
      m.bready <= 1'b0;
      m.awaddr <= '0;
      m.wdata <= '0;
    end else if (go) begin
      active <= 1'b1;
      cnt <= '0;
      m.awvalid <= 1'b1;
      m.wvalid <= 1'b1;
      m.bready <= 1'b0;
      m.awaddr <= addr;
      m.wdata <= data;
    end else if (timeout || b_hs) begin
      active <= 1'b0;
      m.awvalid <= 1'b0;
      m.wvalid <= 1'b0;
      m.bready <= 1'b0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      if (m.awready) m.awvalid <= 1'b0;
      if (m.wready) m.wvalid <= 1'b0;
      if ((!m.awvalid || m.awready) && (!m.wvalid || m.wready)) m.bready <= 1'b1;
    end
  end
endmodule

// File: rtl/packet_cutter_cfg_sequencer.sv
// packet_cutter_cfg_sequencer: disables cutting, loads word/offset/bytes, then restores enable over AXI4-Lite
module packet_cutter_cfg_sequencer
  import packet_cutter_cfg_sequencer_pkg::*;
#(
  parameter logic [31:0] C_BASE_ADDR = 32'h77800000,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT = 256
) (
  input logic clk,
  input logic reset,
  input logic cfg_start,
  input logic [31:0] cfg_word,
  input logic [31:0] cfg_offset,
  input logic [31:0] cfg_bytes,
  input logic cfg_enable,
  output logic busy,
  output logic done,
  output logic error,
  output logic [2:0] err_index,
  packet_cutter_cfg_sequencer_if.master m_axi
);
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);
  state_t state, state_nxt;
  logic [2:0] step;
  logic [31:0] word_q, offset_q, bytes_q, step_data;
  logic enable_q, go, ok, err;
  assign busy = state == ISSUE || state == WAIT_RESP;
  assign done = state == DONE;
  assign go = state == ISSUE;
  assign step_data = step == 3'd1 ? word_q : step == 3'd2 ? offset_q : step == 3'd3 ? bytes_q :
                     step == 3'd4 ? {31'b0, enable_q} : 32'h0;
  // an error always ends the sequence, so enable is never restored after a failed load
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (cfg_start ? ISSUE : IDLE) :
                state == ISSUE ? WAIT_RESP :
                state == WAIT_RESP ? (err ? DONE : ok ? (step == LAST_STEP ? DONE : ISSUE) : WAIT_RESP) :
                IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step <= '0;
      error <= 1'b0;
      err_index <= '0;
      word_q <= '0;
      offset_q <= '0;
      bytes_q <= '0;
      enable_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cfg_start) begin
        word_q <= cfg_word;
        offset_q <= cfg_offset;
        bytes_q <= cfg_bytes;
        enable_q <= cfg_enable;
        error <= 1'b0;
        err_index <= '0;
        step <= '0;
      end
      if (state == WAIT_RESP && ok && step != LAST_STEP) step <= step + 1'b1;
      if (state == WAIT_RESP && err) begin
        error <= 1'b1;
        err_index <= step;
      end
    end
  end
  axil_single_write #(
    .ADDR_W(C_S_AXI_ADDR_WIDTH),
    .DATA_W(C_S_AXI_DATA_WIDTH),
    .TIMEOUT(C_TIMEOUT)
  ) u_wr (
    .clk(clk),
    .reset(reset),
    .go(go),
    .addr(C_S_AXI_ADDR_WIDTH'(C_BASE_ADDR + step_offset(step))),
    .data(C_S_AXI_DATA_WIDTH'(step_data)),
    .m(m_axi),
    .ok(ok),
    .err(err)
  );
endmodule

// File: tb/tb_packet_cutter_cfg_sequencer.sv
// tb_packet_cutter_cfg_sequencer: directed and randomized sequences against a delay-programmable AXI-Lite slave
module tb_packet_cutter_cfg_sequencer;
  localparam logic [31:0] BASE = 32'h77800000;
  localparam int TMO = 256;
  logic clk = 0;
  logic reset = 1;
  logic cfg_start = 0;
  logic cfg_enable = 0;
  logic [31:0] cfg_word = 0, cfg_offset = 0, cfg_bytes = 0;
  logic busy, done, error;
  logic [2:0] err_index;
  int errors = 0, checks = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, err_step = -1, b_base = 0;
  bit no_b = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit aw_got = 0, w_got = 0, aw_hs_last = 0, w_hs_last = 0, aw_stall = 0, w_stall = 0;
  logic [31:0] cap_addr = 0, cap_data = 0, hold_addr = 0, hold_data = 0;
  logic [31:0] obs_addr[$], obs_data[$];
  int aw_count = 0, b_idx = 0, viol = 0, done_count = 0;
  int wbase = 0, awbase = 0, dbase = 0, vbase = 0;

  always #5 clk = ~clk;

  packet_cutter_cfg_sequencer_if bus ();

  packet_cutter_cfg_sequencer dut (
    .clk(clk),
    .reset(reset),
    .cfg_start(cfg_start),
    .cfg_word(cfg_word),
    .cfg_offset(cfg_offset),
    .cfg_bytes(cfg_bytes),
    .cfg_enable(cfg_enable),
    .busy(busy),
    .done(done),
    .error(error),
    .err_index(err_index),
    .m_axi(bus)
  );

  // slave drives its side on the falling edge, with per-channel wait counts
  always @(negedge clk) begin
    if (reset) begin
      bus.awready = 0;
      bus.wready = 0;
      bus.bvalid = 0;
      bus.bresp = 2'b00;
      aw_cnt = 0;
      w_cnt = 0;
      b_cnt = 0;
    end else begin
      bus.awready = bus.awvalid && !aw_got && aw_cnt >= aw_dly;
      bus.wready = bus.wvalid && !w_got && w_cnt >= w_dly;
      bus.bvalid = aw_got && w_got && !no_b && b_cnt >= b_dly;
      bus.bresp = (b_idx - b_base == err_step) ? 2'b10 : 2'b00;
      aw_cnt = (bus.awvalid && !aw_got) ? aw_cnt + 1 : 0;
      w_cnt = (bus.wvalid && !w_got) ? w_cnt + 1 : 0;
      b_cnt = (aw_got && w_got) ? b_cnt + 1 : 0;
    end
  end

  // monitor: handshakes, completed writes and protocol checks
  always @(posedge clk) begin
    if (reset) begin
      aw_got = 0;
      w_got = 0;
      aw_hs_last = 0;
      w_hs_last = 0;
      aw_stall = 0;
      w_stall = 0;
    end else begin
      if ((aw_hs_last && bus.awvalid) || (w_hs_last && bus.wvalid)) viol++;
      if (aw_stall && (!bus.awvalid || bus.awaddr != hold_addr)) viol++;
      if (w_stall && (!bus.wvalid || bus.wdata != hold_data)) viol++;
      if (bus.wvalid && bus.wstrb != 4'hF) viol++;
      aw_hs_last = bus.awvalid && bus.awready;
      w_hs_last = bus.wvalid && bus.wready;
      aw_stall = bus.awvalid && !bus.awready;
      w_stall = bus.wvalid && !bus.wready;
      hold_addr = bus.awaddr;
      hold_data = bus.wdata;
      if (bus.awvalid && bus.awready) begin
        aw_got = 1;
        cap_addr = bus.awaddr;
        aw_count++;
      end
      if (bus.wvalid && bus.wready) begin
        w_got = 1;
        cap_data = bus.wdata;
      end
      if (bus.bvalid && bus.bready) begin
        obs_addr.push_back(cap_addr);
        obs_data.push_back(cap_data);
        aw_got = 0;
        w_got = 0;
        b_idx++;
      end
      if (done) begin
        done_count++;
        aw_got = 0;
        w_got = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_wr(input int k, input logic [31:0] w, o, b, input logic en);
    logic [31:0] offs[5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
    logic [31:0] vals[5];
    vals = '{32'h0, w, o, b, {31'b0, en}};
    return {BASE + offs[k], vals[k]};
  endfunction

  task automatic run(input logic [31:0] w, o, b, input logic en, input int restart_at, output int cyc);
    @(negedge clk);
    wbase = obs_addr.size();
    awbase = aw_count;
    dbase = done_count;
    vbase = viol;
    b_base = b_idx;
    cfg_word = w;
    cfg_offset = o;
    cfg_bytes = b;
    cfg_enable = en;
    cfg_start = 1;
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      cfg_start = (cyc == restart_at);
      cfg_word = $urandom;
      cfg_offset = $urandom;
      cfg_bytes = ~b;
      cfg_enable = 1'($urandom);
      if (cyc == 1) chk("start_busy_err_clear", 64'({busy, error}), 64'b10);
      if (done) break;
    end
    chk("done_seen", 64'(done), 1);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [31:0] w, o, b, input logic en);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, 64'(done_count - dbase), 1);
    chk({tag, "_idle"}, 64'(busy), 0);
    chk({tag, "_nwrites"}, 64'(obs_addr.size() - wbase), 64'(n));
    chk({tag, "_naw"}, 64'(aw_count - awbase), 64'(n));
    chk({tag, "_protocol"}, 64'(viol - vbase), 0);
    for (int k = 0; k < n && wbase + k < obs_addr.size(); k++)
      chk($sformatf("%s_wr%0d", tag, k), {obs_addr[wbase + k], obs_data[wbase + k]}, exp_wr(k, w, o, b, en));
  endtask

  initial begin
    int cyc, es, n;
    logic [31:0] rw, ro, rb;
    logic ren;
    bit found;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_error", 64'(error), 0);
    chk("rst_err_index", 64'(err_index), 0);
    chk("rst_valids", 64'({bus.awvalid, bus.wvalid, bus.bready}), 0);
    chk("rst_awaddr_wdata", {bus.awaddr, bus.wdata}, 0);
    @(negedge clk);
    reset = 0;

    run(32'h1, 32'hffe00000, 32'h4b, 1'b1, 0, cyc);
    chk("zw_latency", 64'(cyc), 16);
    chk("zw_error", 64'(error), 0);
    check_writes("zw", 5, 32'h1, 32'hffe00000, 32'h4b, 1'b1);

    aw_dly = 0;
    w_dly = 3;
    b_dly = 2;
    run(32'h12345678, 32'h0000ff00, 32'h40, 1'b0, 0, cyc);
    chk("slow_error", 64'(error), 0);
    check_writes("slow", 5, 32'h12345678, 32'h0000ff00, 32'h40, 1'b0);
    w_dly = 0;
    b_dly = 0;

    err_step = 2;
    run(32'haa, 32'hbb, 32'hcc, 1'b1, 0, cyc);
    chk("bresp_error", 64'(error), 1);
    chk("bresp_err_index", 64'(err_index), 2);
    check_writes("bresp", 3, 32'haa, 32'hbb, 32'hcc, 1'b1);
    err_step = -1;

    no_b = 1;
    run(32'h5, 32'h6, 32'h7, 1'b1, 0, cyc);
    chk("tmo_latency", 64'(cyc), 64'(TMO + 2));
    chk("tmo_error", 64'(error), 1);
    chk("tmo_err_index", 64'(err_index), 0);
    chk("tmo_aw_count", 64'(aw_count - awbase), 1);
    @(posedge clk);
    #1;
    chk("tmo_valids_low", 64'({bus.awvalid, bus.wvalid, bus.bready}), 0);
    no_b = 0;
    run(32'h9, 32'ha, 32'hb, 1'b1, 0, cyc);
    chk("after_tmo_error", 64'(error), 0);
    check_writes("after_tmo", 5, 32'h9, 32'ha, 32'hb, 1'b1);

    run(32'h11, 32'h22, 32'h33, 1'b1, 5, cyc);
    check_writes("restart", 5, 32'h11, 32'h22, 32'h33, 1'b1);

    for (int r = 0; r < 8; r++) begin
      aw_dly = $urandom_range(0, 3);
      w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3);
      es = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
      err_step = es;
      rw = $urandom;
      ro = $urandom;
      rb = $urandom;
      ren = 1'($urandom);
      run(rw, ro, rb, ren, 0, cyc);
      n = es < 0 ? 5 : es + 1;
      chk("rnd_error", 64'(error), 64'(es >= 0));
      chk("rnd_err_index", 64'(err_index), 64'(es < 0 ? 0 : es));
      check_writes("rnd", n, rw, ro, rb, ren);
    end
    err_step = -1;
    w_dly = 0;
    b_dly = 0;

    aw_dly = 4;
    @(negedge clk);
    b_base = b_idx;
    cfg_start = 1;
    @(posedge clk);
    #1;
    cfg_start = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      found = bus.awvalid && bus.awaddr == BASE + 32'hC;
    end
    chk("midrst_reached_step3", 64'(found), 1);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    chk("midrst_outputs_low", 64'({bus.awvalid, bus.wvalid, bus.bready, busy}), 0);
    @(negedge clk);
    reset = 0;
    aw_dly = 0;
    run(32'hdead, 32'hbeef, 32'h80, 1'b1, 0, cyc);
    chk("midrst_error", 64'(error), 0);
    check_writes("midrst", 5, 32'hdead, 32'hbeef, 32'h80, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
